demux_nto4n_stream: RTL
=======================

// Module: demux_Nto4N_stream
// PURPOSE
//  Registered 1:4 word distributor; inverse of the 4:1 lane mux path. Accepts N-bit words on
//  a valid/ready input and steers each into one of four lane registers, either by S or by an
//  auto-incrementing pointer. Raises frame_valid once all four lanes hold fresh data, e.g. a
//  128-bit AES state assembled from 4x32-bit words for the SIMD lanes.
// PARAMETERS
//  N   32   width of each input word and each lane register
// PORTS
//  clk          in   1   single clock; all state updates on posedge
//  rst          in   1   synchronous, active-low reset
//  en           in   1   block enable; 0 freezes all state, forces in_ready=0
//  auto_mode    in   1   1: target lane = internal ptr; 0: target lane = S
//  S            in   2   lane address used when auto_mode=0
//  I            in   N   input word
//  in_valid     in   1   I is valid
//  in_ready     out  1   combinational: en && (!frame_valid || frame_ready)
//  O0..O3       out  N   lane registers 0..3
//  lane_we      out  4   registered one-hot pulse: lane written in previous cycle
//  frame_valid  out  1   registered: all four lanes filled since last frame handshake
//  frame_ready  in   1   consumer takes the frame
// BEHAVIOUR
//  - Reset (rst=0 at posedge): O0..O3=0, filled=4'b0000, ptr=0, lane_we=0, frame_valid=0.
//    Reset has priority over en and any handshake; mid-frame reset discards partial frame.
//  - acc = en && in_valid && in_ready; tgt = auto_mode ? ptr : S.
//  - On acc: O[tgt]<=I; filled[tgt]<=1; lane_we<=onehot(tgt) next cycle, else lane_we<=0.
//    Latency: word visible on O[tgt] 1 cycle after acceptance.
//  - ptr increments mod 4 only on an acc with auto_mode=1; addressed writes leave ptr.
//  - Rewriting an already-filled lane overwrites data; filled bit stays 1; no error.
//  - frame_valid<=1 on the cycle after filled (including the current write) reaches 4'b1111.
//  - Frame handshake fh = en && frame_valid && frame_ready: frame_valid<=0, ptr<=0,
//    filled<=0; lane data held (O not cleared).
//  - fh and acc in same cycle: frame consumed, then new word counts as first of next frame:
//    filled<=onehot(tgt); ptr<=1 if auto_mode else 0; frame_valid<=0.
//  - frame_valid=1 and frame_ready=0: in_ready=0; O0..O3, filled, ptr stable.
//  - en=0: in_ready=0, frame_ready ignored, all registers hold, lane_we<=0.
//  - auto_mode may change between any two words; ptr continues from its current value.
// STRUCTURE
//  - Package simd_pkg: localparam LANES=4; typedef logic [1:0] lane_idx_t; function
//    onehot4(lane_idx_t) returning logic [3:0].
//  - Sub-module lane_reg_N (N-bit register, sync active-low reset, write enable), 4 instances.
//  - Top holds ptr, filled mask, frame_valid, lane_we and the handshake logic.
// TESTING
//  1 Reset: rst=0 two cycles with in_valid=1 -> O*=0, frame_valid=0, lane_we=0, in_ready=1 after.
//  2 Auto fill: auto_mode=1, send 0xA0,0xA1,0xA2,0xA3 back-to-back, frame_ready=0 -> O0..O3=
//    A0..A3, lane_we 0001,0010,0100,1000, frame_valid=1 cycle after 4th, in_ready=0.
//  3 Addressed + overwrite: auto_mode=0, S=2:0x11, S=2:0x22, S=0,1,3 -> O2=0x22, frame_valid
//    only after 5th word; ptr still 0.
//  4 Simultaneous: frame_valid=1, frame_ready=1, in_valid=1, auto_mode=1, I=0xB0 -> next
//    cycle frame_valid=0, O0=0xB0, filled=0001, ptr=1.
//  5 Backpressure/enable: frame_ready=0 for 5 cycles then 1 -> O* stable, in_ready=0 meanwhile;
//    en=0 with frame_ready=1 -> frame_valid stays 1.
//  6 Reset mid-frame after 2 auto words -> filled=0, ptr=0, next word lands in O0.

Source files
------------

// File: rtl/simd_pkg.sv
// simd_pkg: shared lane count, lane index type and one-hot lane decode
package simd_pkg;
  localparam int LANES = 4;
  typedef logic [1:0] lane_idx_t;
  function automatic logic [3:0] onehot4(lane_idx_t idx);
    return 4'b0001 << idx;
  endfunction
endpackage

// File: rtl/lane_reg_N.sv
// lane_reg_N: N-bit lane register; clk, rst (sync active-low), we, d in, q out
module lane_reg_N #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk)
    if (!rst) q <= '0;
    else if (we) q <= d;
endmodule

// File: rtl/demux_nto4n_stream.sv
// demux_nto4n_stream: 1:4 word distributor; valid/ready word in (I), four lane regs out (O0..O3), frame valid/ready out
module demux_nto4n_stream
  import simd_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         auto_mode,
  input  logic [1:0]   S,
  input  logic [N-1:0] I,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] O0,
  output logic [N-1:0] O1,
  output logic [N-1:0] O2,
  output logic [N-1:0] O3,
  output logic [3:0]   lane_we,
  output logic         frame_valid,
  input  logic         frame_ready
);
  lane_idx_t ptr_q, ptr_d, tgt;
  logic [3:0] filled_q, filled_d, lane_we_q, lane_we_d, wr;
  logic fv_q, fv_d, acc, fh;
  logic [N-1:0] lanes [LANES];
  assign in_ready = en && (!fv_q || frame_ready);
  assign acc = en && in_valid && in_ready;
  assign fh = en && fv_q && frame_ready;
  assign tgt = auto_mode ? ptr_q : lane_idx_t'(S);
  assign wr = acc ? onehot4(tgt) : 4'b0000;
  // A handshake clears the frame first so a same-cycle word starts the next frame
  always_comb begin
    filled_d = (fh ? 4'b0000 : filled_q) | wr;
    ptr_d = (fh ? lane_idx_t'(0) : ptr_q) + lane_idx_t'(acc && auto_mode);
    fv_d = &filled_d;
    lane_we_d = wr;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      ptr_q <= '0;
      filled_q <= '0;
      fv_q <= 1'b0;
      lane_we_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      filled_q <= filled_d;
      fv_q <= fv_d;
      lane_we_q <= lane_we_d;
    end
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lane_reg_N #(.N(N)) u_lane (.clk(clk), .rst(rst), .we(wr[g]), .d(I), .q(lanes[g]));
  end
  assign O0 = lanes[0];
  assign O1 = lanes[1];
  assign O2 = lanes[2];
  assign O3 = lanes[3];
  assign lane_we = lane_we_q;
  assign frame_valid = fv_q;
endmodule
